// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Multi-cycle unsigned subtractor: out = in1 - in2 mod 2^WIDTH, with
//   borrow_out = (in1 < in2). DIGIT bits are processed per clock, LSB digit
//   first, through a single DIGIT-bit subtract cell and a registered borrow.
//   A valid/ready handshake is used on both the operand and result sides.
//   Accept, compute and deliver never overlap: IDLE -> BUSY -> DONE -> IDLE.

module serial_subtractor #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             borrow_out
);

  // Number of digit steps and the counter that walks through them.
  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // One digit of subtraction done at DIGIT+1 bits; the MSB of the result is
  // the borrow passed on to the next digit.
  function automatic logic [DIGIT:0] digit_sub(
    input logic [DIGIT-1:0] a,
    input logic [DIGIT-1:0] b,
    input logic             b_in
  );
    logic [DIGIT:0] r;
    r = {1'b0, a} - {1'b0, b} - {{DIGIT{1'b0}}, b_in};
    return r;
  endfunction

  // Controller state.
  state_t state_r;
  state_t state_s;

  // Registered handshake outputs.
  logic in_ready_r;
  logic out_valid_r;

  // Operand shift registers. The minuend register doubles as the result
  // register: each step consumes its low digit and the new difference digit
  // enters at the MSB end, so after N steps it holds the full difference.
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [CNT_W-1:0] cnt_r;
  logic             borrow_r;

  // Presented result, updated only on the edge that enters DONE.
  logic [WIDTH-1:0] out_r;
  logic             borrow_out_r;

  // Per-step combinational values.
  logic             accept_s;
  logic             deliver_s;
  logic             last_step_s;
  logic [DIGIT:0]   step_s;
  logic [WIDTH-1:0] a_step_s;
  logic [WIDTH-1:0] b_step_s;

  assign accept_s    = (state_r == IDLE) && in_valid && in_ready_r;
  assign deliver_s   = (state_r == DONE) && out_valid_r && out_ready;
  assign last_step_s = (state_r == BUSY) && (cnt_r == LAST_CNT);

  assign step_s   = digit_sub(a_sh_r[DIGIT-1:0], b_sh_r[DIGIT-1:0], borrow_r);
  assign b_step_s = b_sh_r >> DIGIT;

  // A single-digit build has nothing to shift down; otherwise the new digit
  // is placed above the remaining bits.
  generate
    if (DIGIT == WIDTH) begin : g_one_digit
      assign a_step_s = step_s[DIGIT-1:0];
    end else begin : g_multi_digit
      assign a_step_s = {step_s[DIGIT-1:0], a_sh_r[WIDTH-1:DIGIT]};
    end
  endgenerate

  // State register; reset returns to IDLE and aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode: accept in IDLE, count digits in BUSY, hand off in DONE.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = BUSY;
        end else begin
          state_s = IDLE;
        end
      end
      BUSY: begin
        if (last_step_s) begin
          state_s = DONE;
        end else begin
          state_s = BUSY;
        end
      end
      DONE: begin
        if (deliver_s) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Handshake flags registered from the next state so they track the FSM
  // cycle-for-cycle without combinational paths to the ports.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      in_ready_r  <= (state_s == IDLE);
      out_valid_r <= (state_s == DONE);
    end
  end

  // Datapath: capture operands on accept, step one digit per BUSY cycle and
  // latch the final difference and borrow on the last step.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh_r       <= {WIDTH{1'b0}};
      b_sh_r       <= {WIDTH{1'b0}};
      cnt_r        <= CNT_ZERO;
      borrow_r     <= 1'b0;
      out_r        <= {WIDTH{1'b0}};
      borrow_out_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            a_sh_r   <= in1;
            b_sh_r   <= in2;
            cnt_r    <= CNT_ZERO;
            borrow_r <= 1'b0;
          end
        end
        BUSY: begin
          a_sh_r   <= a_step_s;
          b_sh_r   <= b_step_s;
          borrow_r <= step_s[DIGIT];
          cnt_r    <= cnt_r + CNT_ONE;
          if (last_step_s) begin
            out_r        <= a_step_s;
            borrow_out_r <= step_s[DIGIT];
          end
        end
        default: begin
          // DONE and unused encodings hold the datapath.
          a_sh_r <= a_sh_r;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_r;
  assign out_valid  = out_valid_r;
  assign out        = out_r;
  assign borrow_out = borrow_out_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor
//   Two instances: DIGIT=1 (unit 0, N=32) and DIGIT=4 (unit 1, N=8).
//   Expected results are pushed to a per-unit queue at the accept point and
//   popped and compared when the result handshake is about to happen.

module tb_serial_subtractor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, in_valid_a, in_ready_a, out_valid_a, out_ready_a, borrow_a;
  logic [31:0] in1_a, in2_a, out_a;
  logic        rst_b, in_valid_b, in_ready_b, out_valid_b, out_ready_b, borrow_b;
  logic [31:0] in1_b, in2_b, out_b;

  serial_subtractor #(.WIDTH(32), .DIGIT(1)) dut_a (
    .clk(clk), .rst(rst_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .in1(in1_a), .in2(in2_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
    .out(out_a), .borrow_out(borrow_a)
  );

  serial_subtractor #(.WIDTH(32), .DIGIT(4)) dut_b (
    .clk(clk), .rst(rst_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in1(in1_b), .in2(in2_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
    .out(out_b), .borrow_out(borrow_b)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] d;
    logic        bo;
  } vec_t;

  vec_t        vecs[9];
  logic [32:0] q_a[$];
  logic [32:0] q_b[$];
  logic [32:0] e_a, e_b;
  int          total = 0;
  int          bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic set_in(input int u, input logic v, input logic [31:0] x, input logic [31:0] y);
    if (u == 0) begin
      in_valid_a = v; in1_a = x; in2_a = y;
    end else begin
      in_valid_b = v; in1_b = x; in2_b = y;
    end
  endtask

  function automatic logic get_rdy(input int u);
    return (u == 0) ? in_ready_a : in_ready_b;
  endfunction

  function automatic logic get_vld(input int u);
    return (u == 0) ? out_valid_a : out_valid_b;
  endfunction

  task automatic push_exp(input int u, input logic [32:0] e);
    if (u == 0) q_a.push_back(e);
    else        q_b.push_back(e);
  endtask

  // Wait (bounded) until in_ready is seen at a falling edge.
  task automatic wait_ready(input int u);
    int n;
    n = 0;
    @(negedge clk);
    while (!get_rdy(u) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("accept_ready_u%0d", u), {31'd0, get_rdy(u)}, 32'd1);
  endtask

  // Wait (bounded) for out_valid after an accept edge; returns edges elapsed.
  task automatic wait_result(input int u, output int lat);
    lat = 0;
    @(negedge clk);
    while (!get_vld(u) && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // One complete operation with out_ready held high; operands are scrambled
  // right after the accept edge.
  task automatic op(input int u, input logic [31:0] x, input logic [31:0] y,
                    input logic [31:0] d, input logic bo);
    int lat;
    set_in(u, 1'b1, x, y);
    wait_ready(u);
    push_exp(u, {bo, d});
    @(posedge clk); #1;
    set_in(u, 1'b0, $urandom, $urandom);
    wait_result(u, lat);
    check($sformatf("latency_u%0d", u), 32'(lat), (u == 0) ? 32'd32 : 32'd8);
    @(posedge clk); #1;
  endtask

  // Scoreboard: a result handshake occurs at the next rising edge.
  always @(negedge clk) begin
    if (!rst_a && out_valid_a && out_ready_a) begin
      if (q_a.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_result_a: actual=%h required=none", out_a);
      end else begin
        e_a = q_a.pop_front();
        check("diff_a", out_a, e_a[31:0]);
        check("borrow_a", {31'd0, borrow_a}, {31'd0, e_a[32]});
      end
    end
    if (!rst_b && out_valid_b && out_ready_b) begin
      if (q_b.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_result_b: actual=%h required=none", out_b);
      end else begin
        e_b = q_b.pop_front();
        check("diff_b", out_b, e_b[31:0]);
        check("borrow_b", {31'd0, borrow_b}, {31'd0, e_b[32]});
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [31:0] x, y;

    vecs[0] = '{32'd10,         32'd3,          32'h00000007, 1'b0};
    vecs[1] = '{32'd3,          32'd10,         32'hFFFFFFF9, 1'b1};
    vecs[2] = '{32'd0,          32'd0,          32'h00000000, 1'b0};
    vecs[3] = '{32'hFFFFFFFF,   32'h00000001,   32'hFFFFFFFE, 1'b0};
    vecs[4] = '{32'h00000000,   32'hFFFFFFFF,   32'h00000001, 1'b1};
    vecs[5] = '{32'h80000000,   32'h00000001,   32'h7FFFFFFF, 1'b0};
    vecs[6] = '{32'h12345678,   32'h12345678,   32'h00000000, 1'b0};
    vecs[7] = '{32'h00000001,   32'h00000002,   32'hFFFFFFFF, 1'b1};
    vecs[8] = '{32'hDEADBEEF,   32'h12345678,   32'hCC796877, 1'b0};

    rst_a = 1'b1; rst_b = 1'b1;
    set_in(0, 1'b0, 32'd0, 32'd0);
    set_in(1, 1'b0, 32'd0, 32'd0);
    out_ready_a = 1'b1; out_ready_b = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready_a",  {31'd0, in_ready_a},  32'd1);
    check("rst_out_valid_a", {31'd0, out_valid_a}, 32'd0);
    check("rst_out_a",       out_a,                32'd0);
    check("rst_borrow_a",    {31'd0, borrow_a},    32'd0);
    check("rst_in_ready_b",  {31'd0, in_ready_b},  32'd1);
    check("rst_out_valid_b", {31'd0, out_valid_b}, 32'd0);
    @(posedge clk); #1;
    rst_a = 1'b0; rst_b = 1'b0;

    // Table vectors on both digit widths.
    for (int i = 0; i < 9; i++) op(0, vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].bo);
    for (int i = 0; i < 9; i++) op(1, vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].bo);

    // Result held in DONE with out_ready low while new operands are offered.
    out_ready_a = 1'b0;
    set_in(0, 1'b1, 32'd50, 32'd20);
    wait_ready(0);
    push_exp(0, {1'b0, 32'd30});
    @(posedge clk); #1;
    in1_a = 32'd9; in2_a = 32'd4;
    wait_result(0, lat);
    check("hold_latency", 32'(lat), 32'd32);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      check("hold_out_valid", {31'd0, out_valid_a}, 32'd1);
      check("hold_in_ready",  {31'd0, in_ready_a},  32'd0);
      check("hold_out",       out_a,                32'd30);
    end
    @(posedge clk); #1;
    out_ready_a = 1'b1;
    push_exp(0, {1'b0, 32'd5});
    @(posedge clk);
    @(negedge clk);
    check("release_in_ready",  {31'd0, in_ready_a},  32'd1);
    check("release_out_valid", {31'd0, out_valid_a}, 32'd0);
    @(posedge clk); #1;
    in_valid_a = 1'b0;
    wait_result(0, lat);
    check("release_latency", 32'(lat), 32'd32);
    @(posedge clk); #1;

    // Reset during BUSY step 15 of 100-37; that result must never appear.
    set_in(0, 1'b1, 32'd100, 32'd37);
    wait_ready(0);
    @(posedge clk); #1;
    in_valid_a = 1'b0;
    repeat (15) @(posedge clk);
    #1 rst_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_in_ready",  {31'd0, in_ready_a},  32'd1);
    check("abort_out_valid", {31'd0, out_valid_a}, 32'd0);
    check("abort_out",       out_a,                32'd0);
    check("abort_borrow",    {31'd0, borrow_a},    32'd0);
    rst_a = 1'b0;
    @(posedge clk); #1;
    op(0, 32'd5, 32'd2, 32'd3, 1'b0);

    // Random sweep on the DIGIT=4 build.
    for (int i = 0; i < 1000; i++) begin
      x = $urandom;
      y = (i % 10 == 0) ? x : $urandom;
      op(1, x, y, x - y, (x < y) ? 1'b1 : 1'b0);
    end

    repeat (5) @(negedge clk);
    check("sb_empty_a", 32'(q_a.size()), 32'd0);
    check("sb_empty_b", 32'(q_b.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
